tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, bits per channel word (WIDTH >= 2).
REQ-002 SHALL provide ports, one per line (name, direction, width, meaning):
  clk  input  1  single clock; all state on rising edge
  rst  input  1  reset, synchronous, active-high
  sin  input  1  serial TDM data bit
  sin_valid  input  1  sin carries a slot this cycle
  frame  input  1  marks slot 0 of a frame; qualified by sin_valid
  out_a  output  WIDTH  channel A word (even slots)
  out_b  output  WIDTH  channel B word (odd slots)
  out_valid  output  1  out_a/out_b hold a completed frame
  out_ready  input  1  consumer accepts the frame
  err  output  1  one-cycle error pulse
REQ-003 SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 SHALL receive a stream of 2*WIDTH data slots per frame, interleaved A,B,A,B, MSB first: slot 2k = A bit WIDTH-1-k, slot 2k+1 = B bit WIDTH-1-k.
REQ-005 SHALL capture sin only in cycles with sin_valid=1; slot counter SHALL hold while sin_valid=0.
REQ-006 SHALL implement states IDLE, COLLECT, HOLD.
REQ-007 IDLE: sin_valid=1 with frame=1 SHALL capture slot 0 that cycle and go to COLLECT; sin_valid with frame=0 SHALL be ignored.
REQ-008 COLLECT: each valid slot SHALL shift into the A or B shift register by slot parity and increment the slot counter.
REQ-009 On capture of the final slot, out_a/out_b SHALL load from the shift registers and out_valid SHALL rise on the next cycle (latency 1 cycle); state SHALL become HOLD.
REQ-010 out_a/out_b SHALL change only on frame completion; stable throughout HOLD.
REQ-011 HOLD: out_valid=1 and out_ready=1 in the same cycle SHALL complete the handshake; out_valid SHALL be 0 the next cycle and state SHALL return to IDLE.
REQ-012 HOLD with handshake completing and sin_valid=1, frame=1 in the same cycle SHALL accept the new slot 0 and enter COLLECT (no bubble).
REQ-013 HOLD with sin_valid=1, frame=1 and no handshake SHALL pulse err, drop that frame's slots until the next accepted frame start, keep out_a/out_b/out_valid unchanged.
REQ-014 frame=1 with sin_valid=1 during COLLECT SHALL pulse err, discard partial data, and restart at slot 0 with the current bit.
REQ-015 The slot counter SHALL be wide enough for 2*WIDTH (+1 with parity) slots and SHALL never wrap inside a frame.
REQ-016 err SHALL be high for exactly one cycle per error event.

Reset
REQ-017 rst=1 SHALL force IDLE, slot counter 0, shift registers 0, out_a=0, out_b=0, out_valid=0, err=0 on the next clock edge.
REQ-018 rst during COLLECT or HOLD SHALL abandon the frame with no err pulse; rst SHALL take priority over all inputs.

Configuration
REQ-019 Macro TDM_DEMUX_PARITY_EN SHALL control a parity slot.
REQ-020 With TDM_DEMUX_PARITY_EN defined: frame SHALL be 2*WIDTH+1 slots; final slot is even parity (XOR of all 2*WIDTH+1 bits = 0 is good); good parity SHALL complete as REQ-009; bad parity SHALL pulse err, not assert out_valid, leave out_a/out_b unchanged, return to IDLE.
REQ-021 Without the macro: frame SHALL be exactly 2*WIDTH slots; no parity check logic present.

Verification (WIDTH=8)
REQ-022 Frame slots 1,0,0,0,1,1,0,1,0,1,1,1,0,0,1,0 (frame on first), out_ready=1 -> out_a=8'hA5, out_b=8'h3C, out_valid high one cycle after last slot, then low.
REQ-023 Same frame, sin_valid gaps of 3 cycles between slots, out_ready=0 for 5 cycles -> same words, out_valid held, outputs stable until out_ready.
REQ-024 frame re-asserted at slot 9 -> err one-cycle pulse, following full frame A=8'hFF,B=8'h00 decoded correctly.
REQ-025 New frame start while HOLD and out_ready=0 -> err pulse, out_a=8'hA5/out_b=8'h3C unchanged; handshake+frame start same cycle -> new frame accepted.
REQ-026 rst asserted at slot 7 -> all outputs 0 next cycle, no err; next frame decodes correctly.
REQ-027 With TDM_DEMUX_PARITY_EN: 8'hA5/8'h3C plus parity 0 -> out_valid; parity 1 -> err pulse, out_valid stays 0.

Source files
------------

// File: rtl/tdm_demux.sv
// Serial TDM demultiplexer: A/B interleaved slots, MSB first, into two words.
// Define TDM_DEMUX_PARITY_EN to append an even-parity slot to each frame.
module tdm_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int NSLOT = 2 * WIDTH + 1;
`else
  localparam int NSLOT = 2 * WIDTH;
`endif
  localparam int CW = $clog2(NSLOT + 1);
  localparam logic [CW-1:0] LAST = CW'(NSLOT - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sa, sa_n;
  logic [WIDTH-1:0] sb, sb_n;
  logic [WIDTH-1:0] oa_n, ob_n;
  logic             ov_n, err_n;
  logic             start, go;
`ifdef TDM_DEMUX_PARITY_EN
  logic             par, par_n;
`endif

  assign start = sin_valid & frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sa        <= '0;
      sb        <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sa        <= sa_n;
      sb        <= sb_n;
      out_a     <= oa_n;
      out_b     <= ob_n;
      out_valid <= ov_n;
      err       <= err_n;
`ifdef TDM_DEMUX_PARITY_EN
      par       <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sa_n    = sa;
    sb_n    = sb;
    oa_n    = out_a;
    ob_n    = out_b;
    ov_n    = out_valid;
    err_n   = 1'b0;
    go      = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    par_n   = par;
`endif
    unique case (state)
      IDLE: begin
        if (start) go = 1'b1;
      end
      COLLECT: begin
        if (sin_valid) begin
          if (frame) begin
            err_n = 1'b1;
            go    = 1'b1;
          end else if (cnt == LAST) begin
`ifdef TDM_DEMUX_PARITY_EN
            if (par ^ sin) begin
              err_n   = 1'b1;
              state_n = IDLE;
            end else begin
              oa_n    = sa;
              ob_n    = sb;
              ov_n    = 1'b1;
              state_n = HOLD;
            end
`else
            oa_n    = sa;
            ob_n    = {sb[WIDTH-2:0], sin};
            ov_n    = 1'b1;
            state_n = HOLD;
`endif
          end else begin
            if (cnt[0]) sb_n = {sb[WIDTH-2:0], sin};
            else        sa_n = {sa[WIDTH-2:0], sin};
            cnt_n = cnt + CW'(1);
`ifdef TDM_DEMUX_PARITY_EN
            par_n = par ^ sin;
`endif
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          ov_n    = 1'b0;
          state_n = IDLE;
          if (start) go = 1'b1;
        end else if (start) begin
          // Frame start while the previous frame is unclaimed: drop it.
          err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (go) begin
      state_n = COLLECT;
      sa_n    = {{(WIDTH-1){1'b0}}, sin};
      sb_n    = '0;
      cnt_n   = CW'(1);
`ifdef TDM_DEMUX_PARITY_EN
      par_n   = sin;
`endif
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux, WIDTH=8; parity checks run when
// TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux;
  localparam int W = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int NS = 2 * W + 1;
`else
  localparam int NS = 2 * W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         frame = 1'b0;
  logic [W-1:0] out_a, out_b;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         err;

  int vectors = 0;
  int miscompares = 0;

  tdm_demux #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
    .frame(frame), .out_a(out_a), .out_b(out_b),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic sbit(logic [W-1:0] a, logic [W-1:0] b,
                                int k, logic flip);
    if (k >= 2 * W) return (^{a, b}) ^ flip;
    if (k % 2 == 0) return a[W-1-k/2];
    return b[W-1-k/2];
  endfunction

  task automatic slot(logic b, logic f);
    sin = b;
    sin_valid = 1'b1;
    frame = f;
    step();
    sin_valid = 1'b0;
    frame = 1'b0;
  endtask

  task automatic send(logic [W-1:0] a, logic [W-1:0] b,
                      int from, int to, int gap, logic flip);
    for (int k = from; k <= to; k++) begin
      slot(sbit(a, b, k, flip), k == 0);
      if (k != to) repeat (gap) step();
    end
  endtask

  initial begin
    repeat (2) step();
    chk("rst_a", 32'(out_a), 32'h0);
    chk("rst_b", 32'(out_b), 32'h0);
    chk("rst_v", 32'(out_valid), 32'h0);
    chk("rst_e", 32'(err), 32'h0);
    rst = 1'b0;
    step();

    out_ready = 1'b1;
    send(8'hA5, 8'h3C, 0, NS - 1, 0, 1'b0);
    chk("f1_v", 32'(out_valid), 32'h1);
    chk("f1_a", 32'(out_a), 32'hA5);
    chk("f1_b", 32'(out_b), 32'h3C);
    chk("f1_e", 32'(err), 32'h0);
    step();
    chk("f1_vlow", 32'(out_valid), 32'h0);

    out_ready = 1'b0;
    send(8'hA5, 8'h3C, 0, NS - 1, 3, 1'b0);
    chk("gap_v", 32'(out_valid), 32'h1);
    repeat (5) step();
    chk("hold_v", 32'(out_valid), 32'h1);
    chk("hold_a", 32'(out_a), 32'hA5);
    chk("hold_b", 32'(out_b), 32'h3C);
    out_ready = 1'b1;
    step();
    chk("gap_vlow", 32'(out_valid), 32'h0);

    send(8'h5A, 8'hC3, 0, 8, 0, 1'b0);
    slot(1'b1, 1'b1);
    chk("restart_e", 32'(err), 32'h1);
    send(8'hFF, 8'h00, 1, 1, 0, 1'b0);
    chk("restart_e1", 32'(err), 32'h0);
    send(8'hFF, 8'h00, 2, NS - 1, 0, 1'b0);
    chk("restart_v", 32'(out_valid), 32'h1);
    chk("restart_a", 32'(out_a), 32'hFF);
    chk("restart_b", 32'(out_b), 32'h00);
    step();

    out_ready = 1'b0;
    send(8'hA5, 8'h3C, 0, NS - 1, 0, 1'b0);
    slot(1'b1, 1'b1);
    chk("ovr_e", 32'(err), 32'h1);
    chk("ovr_a", 32'(out_a), 32'hA5);
    chk("ovr_b", 32'(out_b), 32'h3C);
    chk("ovr_v", 32'(out_valid), 32'h1);
    send(8'hFF, 8'hFF, 1, NS - 1, 0, 1'b0);
    chk("drop_e", 32'(err), 32'h0);
    chk("drop_a", 32'(out_a), 32'hA5);
    chk("drop_b", 32'(out_b), 32'h3C);
    out_ready = 1'b1;
    slot(sbit(8'h12, 8'h34, 0, 1'b0), 1'b1);
    chk("nb_v", 32'(out_valid), 32'h0);
    chk("nb_e", 32'(err), 32'h0);
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1, NS - 1, 0, 1'b0);
    chk("nb_fv", 32'(out_valid), 32'h1);
    chk("nb_a", 32'(out_a), 32'h12);
    chk("nb_b", 32'(out_b), 32'h34);
    out_ready = 1'b1;
    step();

    send(8'hA5, 8'h3C, 0, 6, 0, 1'b0);
    rst = 1'b1;
    slot(sbit(8'hA5, 8'h3C, 7, 1'b0), 1'b0);
    rst = 1'b0;
    chk("mrst_a", 32'(out_a), 32'h0);
    chk("mrst_b", 32'(out_b), 32'h0);
    chk("mrst_v", 32'(out_valid), 32'h0);
    chk("mrst_e", 32'(err), 32'h0);
    send(8'h5A, 8'hC3, 0, NS - 1, 0, 1'b0);
    chk("post_v", 32'(out_valid), 32'h1);
    chk("post_a", 32'(out_a), 32'h5A);
    chk("post_b", 32'(out_b), 32'hC3);
    step();

`ifdef TDM_DEMUX_PARITY_EN
    send(8'hA5, 8'h3C, 0, NS - 1, 0, 1'b0);
    chk("par_ok_v", 32'(out_valid), 32'h1);
    chk("par_ok_a", 32'(out_a), 32'hA5);
    step();
    send(8'h12, 8'h34, 0, NS - 1, 0, 1'b1);
    chk("par_bad_e", 32'(err), 32'h1);
    chk("par_bad_v", 32'(out_valid), 32'h0);
    chk("par_bad_a", 32'(out_a), 32'hA5);
    step();
    chk("par_bad_e1", 32'(err), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
